// File: rtl/ni_injector.sv
// Local-port packetizer: queues {dstX,dstY,len} requests and serialises each as header + 0..3 body flits.
// Optional NI_INJECTOR_SEQ_NUM_EN adds a 4-bit packet sequence number in header bits [4C+5:4C+2].
module ni_injector #(
  parameter int unsigned COORD_W = 2,
  parameter int unsigned POS_X   = 0,
  parameter int unsigned POS_Y   = 0,
  parameter int unsigned FLIT_W  = 32,
  parameter int unsigned DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [COORD_W-1:0] req_dstX,
  input  logic [COORD_W-1:0] req_dstY,
  input  logic [1:0]         req_len,
  input  logic               body_valid,
  output logic               body_ready,
  input  logic [FLIT_W-1:0]  body_data,
  output logic               flit_valid,
  input  logic               flit_ready,
  output logic [FLIT_W-1:0]  flit_data,
  output logic               flit_head,
  output logic               flit_tail,
  output logic               err_self
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = 2*COORD_W + 2;
  localparam int unsigned C  = COORD_W;

  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

  logic [EW-1:0]      mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        count_q;
  logic               full, empty, push, pop;
  logic [COORD_W-1:0] q_dst_x, q_dst_y;
  logic [1:0]         q_len;
  logic               self_hit;

  state_t             state_q;
  logic [COORD_W-1:0] dst_x_q, dst_y_q;
  logic [1:0]         len_q;
  logic [1:0]         cnt_q;
  logic               err_self_q;
  logic [FLIT_W-1:0]  header;
`ifdef NI_INJECTOR_SEQ_NUM_EN
  logic [3:0]         seq_q;
`endif

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign {q_dst_x, q_dst_y, q_len} = mem_q[rd_ptr_q];
  assign self_hit  = (q_dst_x == COORD_W'(POS_X)) && (q_dst_y == COORD_W'(POS_Y));
  // The in-flight entry stays queued until its header transfers, so it occupies a slot.
  assign pop       = ((state_q == IDLE) && !empty && self_hit) ||
                     ((state_q == HEAD) && flit_ready);
  assign err_self  = err_self_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {req_dstX, req_dstY, req_len};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      dst_x_q    <= '0;
      dst_y_q    <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      err_self_q <= 1'b0;
`ifdef NI_INJECTOR_SEQ_NUM_EN
      seq_q      <= '0;
`endif
    end else begin
      err_self_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!empty) begin
            if (self_hit) begin
              err_self_q <= 1'b1;
            end else begin
              dst_x_q <= q_dst_x;
              dst_y_q <= q_dst_y;
              len_q   <= q_len;
              state_q <= HEAD;
            end
          end
        end
        HEAD: begin
          if (flit_ready) begin
            cnt_q   <= len_q;
            state_q <= (len_q == 2'd0) ? IDLE : BODY;
`ifdef NI_INJECTOR_SEQ_NUM_EN
            seq_q   <= seq_q + 4'd1;
`endif
          end
        end
        BODY: begin
          if (body_valid && flit_ready) begin
            cnt_q <= cnt_q - 2'd1;
            if (cnt_q == 2'd1) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    header = '0;
    header[C-1:0]     = dst_x_q;
    header[2*C-1:C]   = dst_y_q;
    header[3*C-1:2*C] = COORD_W'(POS_X);
    header[4*C-1:3*C] = COORD_W'(POS_Y);
    header[4*C+1:4*C] = len_q;
`ifdef NI_INJECTOR_SEQ_NUM_EN
    header[4*C+5:4*C+2] = seq_q;
`endif
  end

  always_comb begin
    flit_valid = 1'b0;
    flit_data  = '0;
    flit_head  = 1'b0;
    flit_tail  = 1'b0;
    body_ready = 1'b0;
    case (state_q)
      HEAD: begin
        flit_valid = 1'b1;
        flit_data  = header;
        flit_head  = 1'b1;
        flit_tail  = (len_q == 2'd0);
      end
      BODY: begin
        flit_valid = body_valid;
        flit_data  = body_data;
        flit_tail  = (cnt_q == 2'd1);
        body_ready = body_valid && flit_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ni_injector.sv
// Bench for ni_injector at POS=(1,1): expected flit stream is built from each accepted request
// and compared against every transfer seen on the local port.
module tb_ni_injector;

`ifdef NI_INJECTOR_SEQ_NUM_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_dstX = '0, req_dstY = '0, req_len = '0;
  logic        body_valid = 1'b0;
  logic        body_ready;
  logic [31:0] body_data = '0;
  logic        flit_valid;
  logic        flit_ready = 1'b1;
  logic [31:0] flit_data;
  logic        flit_head, flit_tail, err_self;

  always #5 clk = ~clk;

  ni_injector #(.COORD_W(2), .POS_X(1), .POS_Y(1), .FLIT_W(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dstX(req_dstX), .req_dstY(req_dstY), .req_len(req_len),
    .body_valid(body_valid), .body_ready(body_ready), .body_data(body_data),
    .flit_valid(flit_valid), .flit_ready(flit_ready), .flit_data(flit_data),
    .flit_head(flit_head), .flit_tail(flit_tail), .err_self(err_self)
  );

  typedef struct packed {logic [31:0] d; logic h; logic t;} flit_t;

  flit_t       exp_q[$];
  logic [31:0] body_src[$];
  logic [31:0] hdr_obs[$];
  int          hdr_cycs[$];
  int          checks = 0, errors = 0;
  int          cyc = 0, acc = 0, brc = 0, err_obs = 0, exp_err = 0;
  int          seq_m = 0, last_acc_cyc = 0;
  bit          rand_mode = 1'b0, bubble_once = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: a packet is a header word built by arithmetic plus len random body words.
  task automatic model_push(input int dx, input int dy, input int len);
    logic [31:0] w;
    if (dx == 1 && dy == 1) begin
      exp_err++;
    end else begin
      w = 32'(dx + dy*4 + 1*16 + 1*64 + len*256 + (SEQ_EN ? seq_m*1024 : 0));
      seq_m = (seq_m + 1) % 16;
      exp_q.push_back('{d: w, h: 1'b1, t: (len == 0)});
      for (int i = 0; i < len; i++) begin
        w = $urandom;
        body_src.push_back(w);
        exp_q.push_back('{d: w, h: 1'b0, t: (i == len-1)});
      end
    end
  endtask

  task automatic step();
    flit_t f;
    bit consumed, gate;
    @(negedge clk);
    consumed = 1'b0;
    if (exp_q.size() > 0 && !exp_q[0].h) begin
      check("body_flit_valid", {31'd0, flit_valid}, {31'd0, body_valid});
      check("body_ready", {31'd0, body_ready}, {31'd0, body_valid & flit_ready});
    end else begin
      check("body_ready_zero", {31'd0, body_ready}, 32'd0);
    end
    if (flit_valid === 1'b1 && flit_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_flit", 32'd1, 32'd0);
      end else begin
        f = exp_q.pop_front();
        check("flit_data", flit_data, f.d);
        check("flit_head", {31'd0, flit_head}, {31'd0, f.h});
        check("flit_tail", {31'd0, flit_tail}, {31'd0, f.t});
        if (flit_head) begin
          hdr_obs.push_back(flit_data);
          hdr_cycs.push_back(cyc);
        end
      end
    end
    if (body_ready === 1'b1) begin consumed = 1'b1; brc++; end
    if (err_self === 1'b1) err_obs++;
    if (req_valid && req_ready === 1'b1) begin
      model_push(int'(req_dstX), int'(req_dstY), int'(req_len));
      acc++;
      last_acc_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (consumed && body_src.size() > 0) void'(body_src.pop_front());
    req_valid = 1'b0;
    if (rand_mode) flit_ready = ($urandom_range(0, 3) != 0);
    if (consumed && bubble_once) begin
      gate = 1'b0;
      bubble_once = 1'b0;
    end else begin
      gate = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
    body_valid = gate && (body_src.size() > 0);
    body_data  = body_valid ? body_src[0] : $urandom;
  endtask

  task automatic push(input int dx, input int dy, input int len);
    int a0;
    a0 = acc;
    for (int i = 0; i < 300 && acc == a0; i++) begin
      req_dstX = 2'(dx); req_dstY = 2'(dy); req_len = 2'(len);
      req_valid = 1'b1;
      step();
    end
    if (acc == a0) check("push_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && (exp_q.size() > 0 || body_src.size() > 0); i++) step();
    if (exp_q.size() > 0 || body_src.size() > 0) check("drain_timeout", 32'd1, 32'd0);
    repeat (3) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    body_src.delete();
    seq_m = 0;
    body_valid = 1'b0;
    check("rst_flit_valid", {31'd0, flit_valid}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_body_ready", {31'd0, body_ready}, 32'd0);
  endtask

  initial begin
    logic [31:0] hw;
    int b0, a0, n0, dx, dy;

    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_flit_valid", {31'd0, flit_valid}, 32'd0);
    check("reset_flit_head", {31'd0, flit_head}, 32'd0);
    check("reset_flit_tail", {31'd0, flit_tail}, 32'd0);
    check("reset_flit_data", flit_data, 32'd0);
    check("reset_body_ready", {31'd0, body_ready}, 32'd0);
    check("reset_err_self", {31'd0, err_self}, 32'd0);
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);

    // 1: single header-only packet, header two cycles after acceptance
    push(3, 0, 0);
    drain();
    hw = hdr_obs[hdr_obs.size()-1];
    check("t1_hdr_bits", {22'd0, hw[9:0]}, 32'b00_01_01_00_11);
    check("t1_latency", 32'(hdr_cycs[hdr_cycs.size()-1] - last_acc_cyc), 32'd2);

    // back-to-back packets: one idle cycle between tail and next header
    push(2, 2, 0);
    push(0, 3, 0);
    drain();
    check("b2b_gap", 32'(hdr_cycs[hdr_cycs.size()-1] - hdr_cycs[hdr_cycs.size()-2]), 32'd2);

    // 2: len=3 with one bubble before the second body word
    b0 = brc;
    bubble_once = 1'b1;
    push(0, 2, 3);
    drain();
    check("t2_body_ready_pulses", 32'(brc - b0), 32'd3);

    // 3: fill queue while router stalls
    flit_ready = 1'b0;
    a0 = acc;
    for (int i = 0; i < 5; i++) begin
      req_dstX = 2'(i); req_dstY = 2'd2; req_len = 2'($urandom_range(0, 3));
      req_valid = 1'b1;
      step();
      if (i == 3) check("t3_full_req_ready", {31'd0, req_ready}, 32'd0);
    end
    check("t3_accepted", 32'(acc - a0), 32'd4);
    for (int i = 0; i < 10; i++) begin
      step();
      check("t3_stall_valid", {31'd0, flit_valid}, 32'd1);
      check("t3_stall_head", {31'd0, flit_head}, 32'd1);
      check("t3_stall_data", flit_data, exp_q[0].d);
    end
    flit_ready = 1'b1;
    drain();

    // 4: self-destined request dropped, next one still sent
    n0 = err_obs;
    push(1, 1, 2);
    push(2, 1, 0);
    drain();
    check("t4_err_pulses", 32'(err_obs - n0), 32'd1);
    hw = hdr_obs[hdr_obs.size()-1];
    check("t4_next_dstx", {30'd0, hw[1:0]}, 32'd2);

    // 5: reset in the middle of a len=3 body, with more requests queued
    b0 = brc;
    push(0, 2, 3);
    push(3, 3, 1);
    push(2, 0, 2);
    for (int i = 0; i < 50 && brc == b0; i++) step();
    check("t5_reached_body", {31'd0, brc != b0}, 32'd1);
    do_reset();
    repeat (6) step();
    push(3, 2, 1);
    drain();
    hw = hdr_obs[hdr_obs.size()-1];
    check("t5_fresh_hdr", {22'd0, hw[9:0]}, 32'(3 + 2*4 + 16 + 64 + 256));

    // 6: sequence numbers 0..15 then 0 (all zero without the option)
    do_reset();
    n0 = hdr_obs.size();
    for (int i = 0; i < 17; i++) begin
      do dx = $urandom_range(0, 3); while (dx == 1);
      push(dx, $urandom_range(0, 3), 0);
    end
    drain();
    check("t6_hdr_count", 32'(hdr_obs.size() - n0), 32'd17);
    for (int i = 0; i < 17 && n0 + i < hdr_obs.size(); i++) begin
      hw = hdr_obs[n0 + i];
      check("t6_seq", {28'd0, hw[13:10]}, SEQ_EN ? 32'(i % 16) : 32'd0);
    end

    // randomized traffic with backpressure and body gaps
    rand_mode = 1'b1;
    n0 = err_obs;
    a0 = exp_err;
    for (int i = 0; i < 30; i++) begin
      dx = $urandom_range(0, 3);
      dy = $urandom_range(0, 3);
      push(dx, dy, $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) step();
    end
    drain();
    rand_mode = 1'b0;
    flit_ready = 1'b1;
    check("rand_err_pulses", 32'(err_obs - n0), 32'(exp_err - a0));
    check("final_req_ready", {31'd0, req_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ni_injector.md
Name: ni_injector

Overview:
- Local-port packetizer for a mesh router node. Queues injection requests from the core, then serialises each one onto the router's local input as a header flit followed by zero to three body flits.
- The header flit carries the destination coordinates that the downstream route computation decodes into a productive-port vector.
- Requests destined to the node itself are dropped before injection and flagged.

Parameters:
- COORD_W, 2, width of one mesh coordinate.
- POS_X, 0, this node's X coordinate.
- POS_Y, 0, this node's Y coordinate.
- FLIT_W, 32, flit data width. Must be at least 4*COORD_W+6.
- DEPTH, 4, request queue entries. Power of two, at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  injection request valid
- req_ready  out  1  queue can accept; equals !full
- req_dstX  in  COORD_W  destination X
- req_dstY  in  COORD_W  destination Y
- req_len  in  2  number of body flits, 0..3
- body_valid  in  1  body data available
- body_ready  out  1  body word consumed this cycle
- body_data  in  FLIT_W  body flit payload
- flit_valid  out  1  flit presented to router local port
- flit_ready  in  1  router accepts flit
- flit_data  out  FLIT_W  flit payload
- flit_head  out  1  current flit is the header
- flit_tail  out  1  current flit is the last of the packet
- err_self  out  1  one-cycle pulse when a self-destined request is dropped

Behaviour:
- Interface (already decided): one clock, clk. reset is synchronous and active-high.
- Reset values:
  - All outputs 0, except req_ready=1.
  - Queue empty, FSM in IDLE, body counter 0.
  - Reset asserted mid-packet flushes the queue and the in-flight packet. No tail flit is generated.
- Queue (FIFO of {dstX, dstY, len}):
  - Push on req_valid&req_ready.
  - Simultaneous push and pop when not full: both take effect, occupancy unchanged.
  - When full: req_ready=0 and req_valid is ignored.
- Header flit layout:
  - [COORD_W-1:0] dstX
  - [2C-1:C] dstY
  - [3C-1:2C] POS_X
  - [4C-1:3C] POS_Y
  - [4C+1:4C] len
  - All remaining bits 0.
- FSM states IDLE, HEAD, BODY:
  - IDLE, queue empty: stay in IDLE.
  - IDLE, queue entry has dstX==POS_X and dstY==POS_Y: pop it, pulse err_self the next cycle, stay in IDLE. No flits are emitted for it.
  - IDLE, any other queue entry: go to HEAD.
  - HEAD: flit_valid=1, flit_head=1, flit_data=header, flit_tail=(len==0).
    - Hold all flit outputs stable until flit_ready.
    - On transfer, pop the queue and load counter=len.
    - Next state is IDLE if len==0, else BODY.
  - BODY: flit_valid=body_valid, flit_data=body_data, body_ready=body_valid&flit_ready, flit_head=0, flit_tail=(counter==1).
    - Each transfer decrements counter.
    - Transfer with counter==1 returns to IDLE.
    - body_valid low inserts bubbles and leaves the state unchanged.
- Latency:
  - A request accepted at cycle N presents its header at cycle N+2 at the earliest.
  - Back-to-back packets have one IDLE cycle between a tail and the next header.
- body_ready is 0 outside BODY.
- Packets are never interleaved: body flits always belong to the last header sent.

Optional Feature:
- Macro: NI_INJECTOR_SEQ_NUM_EN.
- When defined:
  - A 4-bit packet sequence counter is kept and placed in header bits [4C+5:4C+2].
  - The counter increments on every header transfer and wraps 15->0.
  - Dropped self-destined requests do not consume a number.
  - Reset sets the counter to 0.
- When undefined: those header bits are 0 and no counter exists.

Test Plan:
1. POS=(1,1). Push dst(3,0), len=0 at cycle 0, flit_ready=1. Required: cycle 2 header with flit_head=1, flit_tail=1, flit_data[9:0]=0b00_01_01_00_11. Then IDLE.
2. Push dst(0,2), len=3. Body words A, B, C, with body_valid dropped for one cycle before B. Required: header, then A, bubble, B, C. flit_tail only on C. body_ready pulses exactly 3 times.
3. Push DEPTH+1 requests while flit_ready=0. Required: req_ready=0 after the 4th push; the 5th is not enqueued. The header stays stable across 10 stalled cycles.
4. Push dst(1,1), then dst(2,1), len=0. Required: err_self pulses once and no flit is emitted for the first request. The second header follows with flit_data[1:0]=2.
5. Assert reset during the body of a len=3 packet. Required: next cycle flit_valid=0, req_ready=1, queue empty. A fresh request afterwards produces a correct header.
6. NI_INJECTOR_SEQ_NUM_EN defined. Send 17 non-self packets. Required: sequence field reads 0..15, then 0.
